// File: rtl/pam_frame_syn.sv
// -----------------------------------------------------------------------------
// pam_frame_syn
//
// Frame synchronizer that sits in front of the PAM demodulator. It hunts the
// ADC stream for an alternating-polarity preamble (POS, NEG, POS, ...). When it
// finds one, it forwards exactly one frame (pilot levels followed by PAM data)
// as a contiguous valid burst. It then holds a guard gap so the demodulator
// can return to idle before the next frame.
//
// Optional feature macro: PAM_SYN_OFFSET_BIN_EN
//   defined   : ad_data is offset-binary. Its MSB is inverted before detection
//               and before forwarding.
//   undefined : ad_data is already two's complement and is used unchanged.
//
// Ports
//   clk              in   single clock
//   rst_n            in   asynchronous active-low reset
//   ad_valid         in   ADC sample valid
//   ad_data          in   ADC sample [AD_CVER_WIDTH]
//   syn_demod_ready  in   downstream ready, sampled only at frame start
//   syn_demod_valid  out  frame sample valid (registered)
//   syn_demod_data   out  frame sample (registered, holds while valid is low)
//   frame_start      out  one-cycle pulse with the first valid of a frame
//   frame_abort      out  one-cycle pulse when a frame is truncated
//   busy             out  high while in OUT or GAP
//
// State table
//   HUNT | search for the preamble; when pre_cnt reaches its terminal count,
//        | the next cycle checks ready and may accept the first pilot sample
//   OUT  | forward accepted samples until the frame is complete or the input
//        | drops out
//   GAP  | guard interval of GAP_CYCLES cycles; input is ignored
// -----------------------------------------------------------------------------
module pam_frame_syn #(
    parameter int AD_CVER_WIDTH = 12,
    parameter int LENGTH_DATA   = 1024,
    parameter int PAM_ORDER     = 4,
    parameter int PREAMBLE_LEN  = 32,
    parameter int THRESHOLD     = 512,
    parameter int GAP_CYCLES    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ad_valid,
    input  logic [AD_CVER_WIDTH-1:0] ad_data,
    input  logic                     syn_demod_ready,
    output logic                     syn_demod_valid,
    output logic [AD_CVER_WIDTH-1:0] syn_demod_data,
    output logic                     frame_start,
    output logic                     frame_abort,
    output logic                     busy
);

    localparam int PILOT_LEN = 1 << PAM_ORDER;
    localparam int FRAME_LEN = PILOT_LEN + LENGTH_DATA;
    localparam int PRE_W     = $clog2(PREAMBLE_LEN + 1);
    localparam int OUT_W     = $clog2(FRAME_LEN + 1);
    localparam int GAP_W     = $clog2(GAP_CYCLES + 1);

    localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(PREAMBLE_LEN);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    localparam logic signed [AD_CVER_WIDTH-1:0] THR_POS = AD_CVER_WIDTH'(THRESHOLD);
    localparam logic signed [AD_CVER_WIDTH-1:0] THR_NEG = AD_CVER_WIDTH'(-THRESHOLD);

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_OUT  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                   r_state;
    logic [PRE_W-1:0]         r_pre_cnt;
    logic [OUT_W-1:0]         r_out_cnt;
    logic [GAP_W-1:0]         r_gap_cnt;
    logic                     r_valid;
    logic [AD_CVER_WIDTH-1:0] r_data;
    logic                     r_start;
    logic                     r_abort;

    state_t                   w_state_nxt;
    logic [PRE_W-1:0]         w_pre_cnt_nxt;
    logic [OUT_W-1:0]         w_out_cnt_nxt;
    logic [GAP_W-1:0]         w_gap_cnt_nxt;
    logic                     w_valid_nxt;
    logic [AD_CVER_WIDTH-1:0] w_data_nxt;
    logic                     w_start_nxt;
    logic                     w_abort_nxt;

    logic [AD_CVER_WIDTH-1:0]        w_sample;
    logic signed [AD_CVER_WIDTH-1:0] w_sample_s;
    logic                            w_pos;
    logic                            w_neg;
    logic                            w_match;

`ifdef PAM_SYN_OFFSET_BIN_EN
    assign w_sample = {~ad_data[AD_CVER_WIDTH-1], ad_data[AD_CVER_WIDTH-2:0]};
`else
    assign w_sample = ad_data;
`endif

    assign w_sample_s = w_sample;
    assign w_pos      = (w_sample_s > THR_POS);
    assign w_neg      = (w_sample_s < THR_NEG);
    // An odd count means the last matched sample was POS, so NEG is expected next.
    assign w_match    = r_pre_cnt[0] ? w_neg : w_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_HUNT;
            r_pre_cnt <= '0;
            r_out_cnt <= '0;
            r_gap_cnt <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_start   <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre_cnt <= w_pre_cnt_nxt;
            r_out_cnt <= w_out_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_valid   <= w_valid_nxt;
            r_data    <= w_data_nxt;
            r_start   <= w_start_nxt;
            r_abort   <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pre_cnt_nxt = r_pre_cnt;
        w_out_cnt_nxt = r_out_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_valid_nxt   = 1'b0;
        w_data_nxt    = r_data;
        w_start_nxt   = 1'b0;
        w_abort_nxt   = 1'b0;

        case (r_state)
            S_HUNT: begin
                if (r_pre_cnt == PRE_TC) begin
                    // Decision cycle: ready is checked and, if granted, this
                    // cycle's sample is the first pilot of the frame.
                    w_pre_cnt_nxt = '0;
                    if (syn_demod_ready) begin
                        if (ad_valid) begin
                            w_valid_nxt   = 1'b1;
                            w_data_nxt    = w_sample;
                            w_start_nxt   = 1'b1;
                            w_out_cnt_nxt = OUT_W'(1);
                            w_state_nxt   = S_OUT;
                        end else begin
                            // Input dropped before the first pilot was seen.
                            w_abort_nxt   = 1'b1;
                            w_gap_cnt_nxt = GAP_LOAD;
                            w_state_nxt   = S_GAP;
                        end
                    end
                end else if (ad_valid) begin
                    if (w_match) begin
                        w_pre_cnt_nxt = r_pre_cnt + PRE_W'(1);
                    end else if (w_pos) begin
                        // A POS sample can always restart a preamble.
                        w_pre_cnt_nxt = PRE_W'(1);
                    end else begin
                        w_pre_cnt_nxt = '0;
                    end
                end
            end

            S_OUT: begin
                if (ad_valid) begin
                    w_valid_nxt   = 1'b1;
                    w_data_nxt    = w_sample;
                    w_out_cnt_nxt = r_out_cnt + OUT_W'(1);
                    if (r_out_cnt == OUT_LAST) begin
                        w_out_cnt_nxt = '0;
                        w_gap_cnt_nxt = GAP_LOAD;
                        w_state_nxt   = S_GAP;
                    end
                end else begin
                    w_abort_nxt   = 1'b1;
                    w_out_cnt_nxt = '0;
                    w_gap_cnt_nxt = GAP_LOAD;
                    w_state_nxt   = S_GAP;
                end
            end

            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_pre_cnt_nxt = '0;
                    w_state_nxt   = S_HUNT;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end

            default: begin
                w_pre_cnt_nxt = '0;
                w_out_cnt_nxt = '0;
                w_gap_cnt_nxt = '0;
                w_state_nxt   = S_HUNT;
            end
        endcase
    end

    assign syn_demod_valid = r_valid;
    assign syn_demod_data  = r_data;
    assign frame_start     = r_start;
    assign frame_abort     = r_abort;
    assign busy            = (r_state == S_OUT) || (r_state == S_GAP);

endmodule

// File: tb/tb_pam_frame_syn.sv
module tb_pam_frame_syn;

    localparam int PRE   = 32;
    localparam int FRAME = 1040;
    localparam int GAPC  = 4;
    localparam int THR   = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ad_valid = 1'b0;
    logic [11:0] ad_data = '0;
    logic        syn_demod_ready = 1'b1;
    logic        syn_demod_valid;
    logic [11:0] syn_demod_data;
    logic        frame_start;
    logic        frame_abort;
    logic        busy;

    pam_frame_syn dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ad_valid        (ad_valid),
        .ad_data         (ad_data),
        .syn_demod_ready (syn_demod_ready),
        .syn_demod_valid (syn_demod_valid),
        .syn_demod_data  (syn_demod_data),
        .frame_start     (frame_start),
        .frame_abort     (frame_abort),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: mode 0 = hunting, 1 = forwarding a frame, 2 = guard gap.
    typedef struct packed {
        int          mode;
        int          run;
        int          fwd;
        int          gap;
        logic        v;
        logic        st;
        logic        ab;
        logic        bz;
        logic [11:0] d;
    } mdl_t;

    function automatic logic [11:0] to_tc(logic [11:0] raw);
        logic [11:0] x = raw;
`ifdef PAM_SYN_OFFSET_BIN_EN
        x = raw ^ 12'h800;
`endif
        return x;
    endfunction

    function automatic logic [11:0] enc(int v);
        logic [11:0] x = 12'(v);
`ifdef PAM_SYN_OFFSET_BIN_EN
        x = x ^ 12'h800;
`endif
        return x;
    endfunction

    function automatic int polarity(int s);
        if (s > THR) return 1;
        if (s < -THR) return -1;
        return 0;
    endfunction

    function automatic mdl_t step(mdl_t m, logic v, logic [11:0] raw, logic rdy);
        mdl_t        n = m;
        logic [11:0] x = to_tc(raw);
        logic signed [11:0] xs = x;
        int          s = xs;
        int          want;
        n.v = 1'b0;
        n.st = 1'b0;
        n.ab = 1'b0;
        if (m.mode == 0) begin
            if (m.run == PRE) begin
                n.run = 0;
                if (rdy && v) begin
                    n.v = 1'b1; n.d = x; n.st = 1'b1; n.fwd = 1; n.mode = 1;
                end else if (rdy) begin
                    n.ab = 1'b1; n.mode = 2; n.gap = GAPC;
                end
            end else if (v) begin
                want = (m.run % 2 == 0) ? 1 : -1;
                if (polarity(s) == want) n.run = m.run + 1;
                else n.run = (polarity(s) == 1) ? 1 : 0;
            end
        end else if (m.mode == 1) begin
            if (v) begin
                n.v = 1'b1; n.d = x; n.fwd = m.fwd + 1;
                if (n.fwd == FRAME) begin n.mode = 2; n.gap = GAPC; end
            end else begin
                n.ab = 1'b1; n.mode = 2; n.gap = GAPC;
            end
        end else begin
            n.gap = m.gap - 1;
            if (n.gap == 0) begin n.mode = 0; n.run = 0; end
        end
        n.bz = (n.mode != 0);
        return n;
    endfunction

    mdl_t mdl = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl <= '0;
        else        mdl <= step(mdl, ad_valid, ad_data, syn_demod_ready);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Observations gathered by the compare process.
    int          n_valid = 0, n_start = 0, n_abort = 0;
    int          start_cyc = 0, abort_cyc = 0;
    int          cur_run = 0, last_run = 0;
    int          busy_after_abort = 0;
    bit          trk_busy = 0;
    logic [11:0] first_data = '0, last_data = '0;

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk($sformatf("cycle %0d outputs", cyc),
                    32'({syn_demod_valid, frame_start, frame_abort, busy, syn_demod_data}),
                    32'({mdl.v, mdl.st, mdl.ab, mdl.bz, mdl.d}));
                if (syn_demod_valid) begin
                    n_valid++; cur_run++; last_data = syn_demod_data;
                end else if (cur_run != 0) begin
                    last_run = cur_run; cur_run = 0;
                end
                if (frame_start) begin
                    n_start++; start_cyc = cyc; first_data = syn_demod_data;
                end
                if (frame_abort) begin
                    n_abort++; abort_cyc = cyc; busy_after_abort = 0; trk_busy = 1;
                end
                if (trk_busy) begin
                    if (busy) busy_after_abort++;
                    else trk_busy = 0;
                end
            end
        end
    endtask

    task automatic drive_raw(input logic v, input logic [11:0] d);
        @(negedge clk);
        ad_valid = v;
        ad_data  = d;
    endtask

    task automatic drive(input logic v, input int val);
        drive_raw(v, enc(val));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0);
    endtask

    task automatic send_pre(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, (i % 2 == 0) ? 800 : -800);
    endtask

    int t0, tl, td, s_valid, s_start, s_abort;

    initial begin
        fork
            compare_loop();
        join_none

        repeat (3) @(negedge clk);
        #1;
        chk("reset valid", 32'(syn_demod_valid), 0);
        chk("reset data",  32'(syn_demod_data), 0);
        chk("reset start", 32'(frame_start), 0);
        chk("reset abort", 32'(frame_abort), 0);
        chk("reset busy",  32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Clean frame, then the earliest possible next frame.
        s_valid = n_valid; s_start = n_start; s_abort = n_abort;
        send_pre(PRE);
        t0 = cyc;
        for (int k = 0; k < 16; k++) drive(1'b1, 100 + k);
        for (int k = 0; k < 1024; k++) drive(1'b1, k);
        tl = cyc;
        for (int k = 0; k < GAPC; k++) drive(1'b1, 0);
        chk("clean start latency", 32'(start_cyc - t0), 2);
        chk("clean valid count", 32'(n_valid - s_valid), 1040);
        chk("clean contiguous run", 32'(last_run), 1040);
        chk("clean start pulses", 32'(n_start - s_start), 1);
        chk("clean first data", 32'(first_data), 32'h064);
        chk("clean last data", 32'(last_data), 32'h3FF);
        chk("clean no abort", 32'(n_abort - s_abort), 0);
        send_pre(PRE);
        for (int k = 0; k < 11; k++) drive(1'b1, 12'h077);
        drive(1'b0, 0);
        td = cyc;
        idle(8);
        chk("earliest next start", 32'(start_cyc - tl), 38);
        chk("earliest first data", 32'(first_data), 32'h077);
        chk("short frame abort latency", 32'(abort_cyc - td), 1);

        // Weak preamble at exactly the threshold.
        s_valid = n_valid; s_start = n_start;
        for (int k = 0; k < 40; k++) drive(1'b1, (k % 2 == 0) ? 512 : -512);
        idle(4);
        chk("weak no valid", 32'(n_valid - s_valid), 0);
        chk("weak no start", 32'(n_start - s_start), 0);

        // Broken preamble.
        s_valid = n_valid; s_start = n_start; s_abort = n_abort;
        send_pre(20);
        drive(1'b1, 0);
        send_pre(PRE);
        tl = cyc;
        for (int k = 0; k < FRAME; k++) drive(1'b1, 12'h123 + k);
        idle(8);
        chk("broken start latency", 32'(start_cyc - tl), 2);
        chk("broken first data", 32'(first_data), 32'h123);
        chk("broken start pulses", 32'(n_start - s_start), 1);
        chk("broken valid count", 32'(n_valid - s_valid), 1040);
        chk("broken no abort", 32'(n_abort - s_abort), 0);

        // Ready low at detection, then a normal detection.
        s_valid = n_valid; s_start = n_start;
        syn_demod_ready = 1'b0;
        send_pre(PRE);
        drive(1'b1, 0);
        drive(1'b0, 0);
        syn_demod_ready = 1'b1;
        idle(3);
        chk("ready low no start", 32'(n_start - s_start), 0);
        chk("ready low no valid", 32'(n_valid - s_valid), 0);
        send_pre(PRE);
        tl = cyc;
        for (int k = 0; k < FRAME; k++) drive(1'b1, 3 * k);
        idle(8);
        chk("ready high start pulses", 32'(n_start - s_start), 1);
        chk("ready high start latency", 32'(start_cyc - tl), 2);
        chk("ready high valid count", 32'(n_valid - s_valid), 1040);

        // Mid-frame dropout at frame sample 500.
        s_valid = n_valid; s_start = n_start; s_abort = n_abort;
        send_pre(PRE);
        for (int k = 0; k < 500; k++) drive(1'b1, k + 7);
        drive(1'b0, 0);
        td = cyc;
        for (int k = 0; k < 10; k++) drive(1'b1, 0);
        idle(4);
        chk("dropout abort pulses", 32'(n_abort - s_abort), 1);
        chk("dropout abort latency", 32'(abort_cyc - td), 1);
        chk("dropout valid count", 32'(n_valid - s_valid), 500);
        chk("dropout busy gap cycles", 32'(busy_after_abort), 4);
        chk("dropout start pulses", 32'(n_start - s_start), 1);

        // Asynchronous reset in the middle of a frame.
        s_abort = n_abort;
        send_pre(PRE);
        for (int k = 0; k < 100; k++) drive(1'b1, 12'h200 + k);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset clears outputs",
            32'({syn_demod_valid, frame_start, frame_abort, busy, syn_demod_data}), 0);
        repeat (2) @(negedge clk);
        ad_valid = 1'b0;
        rst_n = 1'b1;
        idle(4);
        chk("async reset no abort", 32'(n_abort - s_abort), 0);

`ifdef PAM_SYN_OFFSET_BIN_EN
        // Offset-binary preamble and data.
        for (int k = 0; k < PRE; k++) drive_raw(1'b1, (k % 2 == 0) ? 12'hB20 : 12'h4E0);
        tl = cyc;
        drive_raw(1'b1, 12'h800);
        for (int k = 1; k < FRAME; k++) drive(1'b1, k);
        idle(8);
        chk("offset start latency", 32'(start_cyc - tl), 2);
        chk("offset first data", 32'(first_data), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
